// File: rtl/hsync_rx_decoder.sv
// Receive-side HSYNC decoder: measures sync pulse / porch widths against nominal
// timing, tracks lock, and regenerates the pixel column index and display strobe.
module hsync_rx_decoder #(
  parameter int unsigned PULSE_CYC  = 384,
  parameter int unsigned BP_CYC     = 192,
  parameter int unsigned PIX_DIV    = 20,
  parameter int unsigned H_PIXELS   = 128,
  parameter int unsigned FP_CYC     = 64,
  parameter int unsigned TOL        = 4,
  parameter int unsigned LOCK_LINES = 2,
  parameter int unsigned CNT_W      = 12,
  localparam int unsigned HPIX_W    = $clog2(H_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  output logic [HPIX_W-1:0] hpixel,
  output logic              pixel_valid,
  output logic              line_start,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  pulse_width
);

  localparam int unsigned DIV_W = $clog2(PIX_DIV);
  localparam int unsigned GL_W  = $clog2(LOCK_LINES + 1);

  localparam logic [CNT_W-1:0]  PULSE_MIN  = CNT_W'(PULSE_CYC - TOL);
  localparam logic [CNT_W-1:0]  PULSE_MAX  = CNT_W'(PULSE_CYC + TOL);
  localparam logic [CNT_W-1:0]  PULSE_STUCK = CNT_W'(PULSE_CYC + TOL + 1);
  localparam logic [CNT_W-1:0]  BP_END     = CNT_W'(BP_CYC);
  localparam logic [CNT_W-1:0]  FP_MIN     = CNT_W'(FP_CYC - TOL);
  localparam logic [CNT_W-1:0]  FP_MAX     = CNT_W'(FP_CYC + TOL);
  localparam logic [CNT_W-1:0]  FP_TIMEOUT = CNT_W'(FP_CYC + TOL + 2);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(PIX_DIV - 1);
  localparam logic [HPIX_W-1:0] HPIX_LAST  = HPIX_W'(H_PIXELS - 1);
  localparam logic [GL_W-1:0]   GL_LOCK    = GL_W'(LOCK_LINES);

  typedef enum logic [2:0] {
    StSearch,
    StPulse,
    StBackporch,
    StDisplay,
    StFrontporch
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_m1;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HPIX_W-1:0] hpix_q, hpix_d;
  logic [GL_W-1:0]   gl_q, gl_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  pw_q, pw_d;
  logic              fall, rise, err, good, ls;

  assign fall   = prev_q & ~sync2_q;
  assign rise   = ~prev_q & sync2_q;
  assign cnt_m1 = cnt_q - CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= StSearch;
      cnt_q    <= '0;
      div_q    <= '0;
      hpix_q   <= '0;
      gl_q     <= '0;
      locked_q <= 1'b0;
      pw_q     <= '0;
    end else begin
      sync1_q  <= hsync_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      hpix_q   <= hpix_d;
      gl_q     <= gl_d;
      locked_q <= locked_d;
      pw_q     <= pw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    hpix_d  = hpix_q;
    pw_d    = pw_q;
    err     = 1'b0;
    good    = 1'b0;
    ls      = 1'b0;
    case (state_q)
      StSearch: begin
        if (fall) begin
          state_d = StPulse;
          cnt_d   = CNT_ONE;
        end
      end
      StPulse: begin
        if (rise) begin
          pw_d = cnt_q;
          if (cnt_q >= PULSE_MIN && cnt_q <= PULSE_MAX) begin
            ls      = 1'b1;
            state_d = StBackporch;
            cnt_d   = CNT_ONE;
          end else begin
            err     = 1'b1;
            state_d = StSearch;
          end
        end else if (cnt_q == PULSE_STUCK) begin
          err     = 1'b1;
          state_d = StSearch;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StBackporch: begin
        if (fall) begin
          err     = 1'b1;
          state_d = StPulse;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == BP_END) begin
          state_d = StDisplay;
          div_d   = '0;
          hpix_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StDisplay: begin
        if (fall) begin
          err     = 1'b1;
          state_d = StPulse;
          cnt_d   = CNT_ONE;
          hpix_d  = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hpix_q == HPIX_LAST) begin
            state_d = StFrontporch;
            cnt_d   = CNT_ONE;
            hpix_d  = '0;
          end else begin
            hpix_d = hpix_q + HPIX_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      StFrontporch: begin
        if (fall) begin
          state_d = StPulse;
          cnt_d   = CNT_ONE;
          if (cnt_m1 >= FP_MIN && cnt_m1 <= FP_MAX) good = 1'b1;
          else                                       err  = 1'b1;
        end else if (cnt_q == FP_TIMEOUT) begin
          err     = 1'b1;
          state_d = StSearch;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Lock follows the good-line count one cycle late; any violation clears both.
  always_comb begin
    gl_d = gl_q;
    if (err)                         gl_d = '0;
    else if (good && gl_q != GL_LOCK) gl_d = gl_q + GL_W'(1);
    locked_d = ~err & (gl_q == GL_LOCK);
  end

  assign pixel_valid = (state_q == StDisplay) && locked_q;
  assign hpixel      = pixel_valid ? hpix_q : '0;
  assign line_start  = ls;
  assign sync_err    = err;
  assign locked      = locked_q;
  assign pulse_width = pw_q;

endmodule
